// File: rtl/ysyx_24090003_pkg.sv
// Shared constants and types for the ysyx_24090003 core slice.
// Holds RV32 widths, the reset PC and the write-back store FSM state encoding.
package ysyx_24090003_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [XLEN-1:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } store_state_e;

endpackage

// File: rtl/ysyx_24090003_regfile.sv
// Architectural GPR file: one write port, two combinational read ports with
// same-cycle write bypass; x0 always reads as zero and is never written.
module ysyx_24090003_regfile
  import ysyx_24090003_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] rd,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2
);

  logic [XLEN-1:0] regs [NREG];

  // NOTE: the array is reset because software may read GPRs before writing
  // them and expects zero; this keeps the array in flops rather than a RAM macro.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && rd != '0) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      regs[rd] <= wdata;
    end
  end

  // Bypass lets the EXU see a result written in the same cycle it is read.
  assign rdata1 = (rs1 == '0)            ? '0    :
                  (we && rd == rs1)      ? wdata : regs[rs1];
  assign rdata2 = (rs2 == '0)            ? '0    :
                  (we && rd == rs2)      ? wdata : regs[rs2];

endmodule

// File: rtl/ysyx_24090003_wbu.sv
// Write-back unit: owns the GPR file and the PC, and issues stores as a
// valid/ready write with a response wait, stalling upstream while outstanding.
module ysyx_24090003_wbu
  import ysyx_24090003_pkg::*;
#(
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst_n,
  input  logic              reg_write_enable,
  input  logic [REG_AW-1:0] EXrd,
  input  logic [XLEN-1:0]   reg_write_data,
  input  logic              addr_write_enable,
  input  logic [XLEN-1:0]   EXaddr,
  input  logic [XLEN-1:0]   addr_write_data,
  input  logic              npc_write_enable,
  input  logic [XLEN-1:0]   EXnpc,
  input  logic              spc_write_enable,
  input  logic [XLEN-1:0]   EXspc,
  input  logic              inst_done,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic [XLEN-1:0]   reg_read_data1,
  output logic [XLEN-1:0]   reg_read_data2,
  output logic [XLEN-1:0]   pc,
  output logic              mem_wvalid,
  output logic [XLEN-1:0]   mem_waddr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_wready,
  input  logic              mem_bvalid,
  output logic              mem_bready,
  output logic              wb_busy
);

  store_state_e state;

  ysyx_24090003_regfile #(
    .NREG(NREG)
  ) u_regfile (
    .cpu_clk  (cpu_clk),
    .cpu_rst_n(cpu_rst_n),
    .we       (reg_write_enable),
    .rd       (EXrd),
    .wdata    (reg_write_data),
    .rs1      (rs1),
    .rs2      (rs2),
    .rdata1   (reg_read_data1),
    .rdata2   (reg_read_data2)
  );

  // Derived from the state flop so an async reset drops it immediately.
  assign wb_busy = (state != ST_IDLE);

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state      <= ST_IDLE;
      mem_wvalid <= 1'b0;
      mem_bready <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (addr_write_enable) begin
            mem_waddr  <= EXaddr & WORD_ALIGN_MASK;
            mem_wdata  <= addr_write_data;
            mem_wvalid <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_wready) begin
            mem_wvalid <= 1'b0;
            mem_bready <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (mem_bvalid) begin
            mem_bready <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          mem_wvalid <= 1'b0;
          mem_bready <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  // A retiring instruction only moves the PC when no store is outstanding.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      pc <= RESET_PC;
    end else if (inst_done && !wb_busy) begin
      if (npc_write_enable)      pc <= EXnpc;
      else if (spc_write_enable) pc <= EXspc;
      else                       pc <= pc + 32'd4;
    end
  end

  a_no_store_while_busy: assert property (
    @(posedge cpu_clk) disable iff (!cpu_rst_n)
      !(addr_write_enable && state != ST_IDLE)
  );

endmodule

// File: tb/tb_ysyx_24090003_wbu.sv
// Directed bench for the write-back unit: GPR file, PC update, store FSM and
// asynchronous reset abort, all against hand-computed expected values.
module tb_ysyx_24090003_wbu;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n;
  logic        reg_write_enable;
  logic [4:0]  EXrd;
  logic [31:0] reg_write_data;
  logic        addr_write_enable;
  logic [31:0] EXaddr;
  logic [31:0] addr_write_data;
  logic        npc_write_enable;
  logic [31:0] EXnpc;
  logic        spc_write_enable;
  logic [31:0] EXspc;
  logic        inst_done;
  logic [4:0]  rs1, rs2;
  logic [31:0] reg_read_data1, reg_read_data2;
  logic [31:0] pc;
  logic        mem_wvalid;
  logic [31:0] mem_waddr, mem_wdata;
  logic        mem_wready, mem_bvalid, mem_bready;
  logic        wb_busy;

  int total = 0;
  int bad   = 0;

  ysyx_24090003_wbu dut (
    .cpu_clk          (cpu_clk),
    .cpu_rst_n        (cpu_rst_n),
    .reg_write_enable (reg_write_enable),
    .EXrd             (EXrd),
    .reg_write_data   (reg_write_data),
    .addr_write_enable(addr_write_enable),
    .EXaddr           (EXaddr),
    .addr_write_data  (addr_write_data),
    .npc_write_enable (npc_write_enable),
    .EXnpc            (EXnpc),
    .spc_write_enable (spc_write_enable),
    .EXspc            (EXspc),
    .inst_done        (inst_done),
    .rs1              (rs1),
    .rs2              (rs2),
    .reg_read_data1   (reg_read_data1),
    .reg_read_data2   (reg_read_data2),
    .pc               (pc),
    .mem_wvalid       (mem_wvalid),
    .mem_waddr        (mem_waddr),
    .mem_wdata        (mem_wdata),
    .mem_wready       (mem_wready),
    .mem_bvalid       (mem_bvalid),
    .mem_bready       (mem_bready),
    .wb_busy          (wb_busy)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs set before the call are sampled on the next rising edge;
  // returns on the following falling edge, where outputs are stable.
  task automatic step();
    @(posedge cpu_clk);
    @(negedge cpu_clk);
  endtask

  task automatic check_store(input string tag, input logic wv, input logic br, input logic busy);
    check({tag, ".wvalid"}, {31'd0, mem_wvalid}, {31'd0, wv});
    check({tag, ".bready"}, {31'd0, mem_bready}, {31'd0, br});
    check({tag, ".busy"},   {31'd0, wb_busy},    {31'd0, busy});
  endtask

  initial begin
    cpu_rst_n = 1'b0;
    reg_write_enable = 1'b0; EXrd = '0; reg_write_data = '0;
    addr_write_enable = 1'b0; EXaddr = '0; addr_write_data = '0;
    npc_write_enable = 1'b0; EXnpc = '0;
    spc_write_enable = 1'b0; EXspc = '0;
    inst_done = 1'b0; rs1 = 5'd5; rs2 = '0;
    mem_wready = 1'b0; mem_bvalid = 1'b0;

    // Reset state
    #12;
    check("rst.pc", pc, 32'h8000_0000);
    check("rst.x5", reg_read_data1, 32'h0);
    check("rst.waddr", mem_waddr, 32'h0);
    check("rst.wdata", mem_wdata, 32'h0);
    check_store("rst", 1'b0, 1'b0, 1'b0);
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    step();
    check("idle.pc", pc, 32'h8000_0000);

    // GPR write then read
    reg_write_enable = 1'b1; EXrd = 5'd5; reg_write_data = 32'hDEAD_BEEF; rs1 = 5'd0;
    step();
    reg_write_enable = 1'b0; rs1 = 5'd5;
    #1 check("gpr.x5", reg_read_data1, 32'hDEAD_BEEF);

    // x0 write dropped, no bypass on x0
    reg_write_enable = 1'b1; EXrd = 5'd0; reg_write_data = 32'h0000_1234; rs2 = 5'd0;
    #1 check("gpr.x0_bypass", reg_read_data2, 32'h0);
    step();
    reg_write_enable = 1'b0;
    #1 check("gpr.x0", reg_read_data2, 32'h0);

    // Same-cycle bypass, then committed value
    reg_write_enable = 1'b1; EXrd = 5'd7; reg_write_data = 32'd5; rs1 = 5'd7; rs2 = 5'd5;
    #1 check("gpr.bypass_x7", reg_read_data1, 32'd5);
    check("gpr.port2_x5", reg_read_data2, 32'hDEAD_BEEF);
    step();
    reg_write_enable = 1'b0;
    #1 check("gpr.x7", reg_read_data1, 32'd5);

    // PC: npc wins over spc
    inst_done = 1'b1; npc_write_enable = 1'b1; spc_write_enable = 1'b1;
    EXnpc = 32'h8000_0100; EXspc = 32'h8000_0200;
    step();
    check("pc.npc", pc, 32'h8000_0100);
    npc_write_enable = 1'b0;
    step();
    check("pc.spc", pc, 32'h8000_0200);
    spc_write_enable = 1'b0;
    step();
    check("pc.plus4", pc, 32'h8000_0204);
    npc_write_enable = 1'b1; EXnpc = 32'hFFFF_FFFC;
    step();
    check("pc.set_top", pc, 32'hFFFF_FFFC);
    npc_write_enable = 1'b0;
    step();
    check("pc.wrap", pc, 32'h0);
    inst_done = 1'b0;
    step();
    check("pc.hold_no_done", pc, 32'h0);

    // Store with delayed wready/bvalid; wready in capture cycle is ignored
    addr_write_enable = 1'b1; EXaddr = 32'h8000_1003; addr_write_data = 32'hA5A5_A5A5;
    mem_wready = 1'b1;
    step();
    addr_write_enable = 1'b0; mem_wready = 1'b0;
    EXaddr = 32'h1111_1111; addr_write_data = 32'h2222_2222;
    check_store("st.req0", 1'b1, 1'b0, 1'b1);
    check("st.waddr", mem_waddr, 32'h8000_1000);
    check("st.wdata", mem_wdata, 32'hA5A5_A5A5);
    // Retire attempt and register write while busy; stray bvalid in REQ
    inst_done = 1'b1; mem_bvalid = 1'b1;
    reg_write_enable = 1'b1; EXrd = 5'd9; reg_write_data = 32'h0000_0077;
    for (int i = 1; i <= 3; i++) begin
      step();
      reg_write_enable = 1'b0;
      check_store($sformatf("st.req%0d", i), 1'b1, 1'b0, 1'b1);
      check($sformatf("st.waddr%0d", i), mem_waddr, 32'h8000_1000);
      check($sformatf("st.wdata%0d", i), mem_wdata, 32'hA5A5_A5A5);
      check($sformatf("st.pc_hold%0d", i), pc, 32'h0);
    end
    mem_bvalid = 1'b0; mem_wready = 1'b1;
    step();
    mem_wready = 1'b0;
    check_store("st.resp0", 1'b0, 1'b1, 1'b1);
    step();
    check_store("st.resp1", 1'b0, 1'b1, 1'b1);
    mem_bvalid = 1'b1;
    step();
    mem_bvalid = 1'b0;
    check_store("st.done", 1'b0, 1'b0, 1'b0);
    check("st.pc_held", pc, 32'h0);
    rs1 = 5'd9;
    #1 check("st.x9_committed", reg_read_data1, 32'h0000_0077);
    // Re-presented retire after the stall
    step();
    inst_done = 1'b0;
    check("st.pc_after", pc, 32'h4);
    step();
    check_store("st.idle", 1'b0, 1'b0, 1'b0);

    // Minimum 3-cycle store with wready and bvalid held high
    addr_write_enable = 1'b1; EXaddr = 32'h0000_0042; addr_write_data = 32'h1357_9BDF;
    mem_wready = 1'b1; mem_bvalid = 1'b1;
    step();
    addr_write_enable = 1'b0;
    check_store("min.req", 1'b1, 1'b0, 1'b1);
    check("min.waddr", mem_waddr, 32'h0000_0040);
    step();
    check_store("min.resp", 1'b0, 1'b1, 1'b1);
    step();
    check_store("min.idle", 1'b0, 1'b0, 1'b0);
    mem_wready = 1'b0; mem_bvalid = 1'b0;

    // Async reset in REQ aborts the store and resets PC and GPRs
    addr_write_enable = 1'b1; EXaddr = 32'h8000_2000; addr_write_data = 32'hCAFE_F00D;
    step();
    addr_write_enable = 1'b0;
    check_store("ar.req", 1'b1, 1'b0, 1'b1);
    #2 cpu_rst_n = 1'b0;
    #1;
    check_store("ar.abort", 1'b0, 1'b0, 1'b0);
    check("ar.pc", pc, 32'h8000_0000);
    check("ar.x9", reg_read_data1, 32'h0);
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    mem_wready = 1'b1; mem_bvalid = 1'b1;
    step();
    check_store("ar.post0", 1'b0, 1'b0, 1'b0);
    step();
    check_store("ar.post1", 1'b0, 1'b0, 1'b0);
    check("ar.waddr", mem_waddr, 32'h0);
    check("ar.pc_stay", pc, 32'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_24090003_wbu.md
# ysyx_24090003_wbu

Write-back unit at the far end of the EXU result interface. It consumes the registered EXU outputs: register write, memory store, next-PC and special-PC redirect. It owns the architectural GPR file and serves the EXU operand read ports. It also owns the PC register. Stores go out as a valid/ready write transaction with a response wait, and the unit raises a stall while a store is outstanding.

## Interface
Parameters:
- NREG, 32, number of GPRs; x0 hardwired to zero.
- RESET_PC, 32'h8000_0000, PC value after reset.

Ports:
- cpu_clk  in  1  sole clock, rising edge
- cpu_rst_n  in  1  asynchronous, active-low reset
- reg_write_enable  in  1  EXU register-write strobe
- EXrd  in  5  destination register
- reg_write_data  in  32  register write value
- addr_write_enable  in  1  EXU store strobe, single-cycle pulse
- EXaddr  in  32  store byte address
- addr_write_data  in  32  store data
- npc_write_enable  in  1  branch/jump redirect strobe
- EXnpc  in  32  redirect target
- spc_write_enable  in  1  special (trap/return) redirect strobe
- EXspc  in  32  special target
- inst_done  in  1  one pulse per retiring instruction
- rs1, rs2  in  5 each  operand read addresses
- reg_read_data1, reg_read_data2  out  32 each  operand values, combinational
- pc  out  32  current PC
- mem_wvalid  out  1  store request valid
- mem_waddr  out  32  store address, word-aligned (bits [1:0] forced 0)
- mem_wdata  out  32  store data
- mem_wready  in  1  request accepted
- mem_bvalid  in  1  store response
- mem_bready  out  1  response ready
- wb_busy  out  1  stall to IFU/EXU

## Operation
- GPR write: on the clock edge with reg_write_enable=1 and EXrd≠0, write the GPR. The write is independent of wb_busy. Writes to x0 are dropped.
- GPR read: index 0 returns 0. When reg_write_enable=1 and EXrd==rsN≠0 in the same cycle, reg_read_data returns reg_write_data (bypass). Otherwise it returns the array value.
- Store FSM, states IDLE, REQ, RESP:
  - IDLE: addr_write_enable=1 captures EXaddr and addr_write_data into holding registers, then → REQ. In any other state addr_write_enable is a protocol violation: ignored and caught by assertion.
  - REQ: mem_wvalid=1. Address and data stay stable until mem_wready=1 at an edge, then → RESP.
  - RESP: mem_bready=1. mem_bvalid=1 → IDLE.
- wb_busy = (state≠IDLE). While busy, upstream freezes and drives all strobes low except reg_write_enable.
- PC update on inst_done=1 with wb_busy=0: npc_write_enable → EXnpc; else spc_write_enable → EXspc; else pc+4. Wrap is modulo 2^32.
- inst_done while busy holds the PC. Upstream re-presents inst_done after the stall.

## Timing
- Reset values: pc=RESET_PC, all GPRs=0, state=IDLE, mem_wvalid=0, mem_bready=0, mem_waddr=0, mem_wdata=0, wb_busy=0.
- Store latency: mem_wvalid rises the cycle after the addr_write_enable edge. The minimum store is 3 cycles IDLE→REQ→RESP→IDLE, when mem_wready and mem_bvalid are both 1 on first sight.
- mem_wready=1 in the same cycle the capture happens has no effect; it is only sampled in REQ.
- mem_bvalid in IDLE or REQ is ignored.
- Simultaneous store capture and register write in one cycle: both take effect.
- Reset mid-store: asynchronous abort. mem_wvalid and wb_busy drop immediately; no response is awaited.
- GPR reads have zero latency. The PC and GPR array update on the clock edge.

## Structure
- The shared package ysyx_24090003_pkg holds:
  - RISC-V constants: XLEN=32, register-index width 5, RESET_PC default.
  - The store-FSM state enum (IDLE/REQ/RESP).
- One sub-module, ysyx_24090003_regfile: NREG×32 array, one write port, two combinational read ports with bypass, x0 zero.
- The store FSM and PC logic stay in the top.

## Test plan
- Reset → pc=32'h8000_0000, reg_read_data1 (rs1=5)=0, mem_wvalid=0, wb_busy=0.
- Write x5=32'hDEAD_BEEF, then rs1=5 → 32'hDEAD_BEEF. Write x0=32'h1234, then rs2=0 → 0. Same-cycle write x7=5 with rs1=7 → 5 (bypass).
- Store EXaddr=32'h8000_1003, data=32'hA5A5_A5A5; mem_wready delayed 3 cycles, mem_bvalid after 2 more → mem_waddr=32'h8000_1000, data stable throughout, wb_busy high for exactly the FSM duration, then IDLE.
- inst_done with npc and spc both set, EXnpc=32'h8000_0100, EXspc=32'h8000_0200 → pc=32'h8000_0100. spc only → 32'h8000_0200. Neither, from pc=32'hFFFF_FFFC → 0.
- inst_done while wb_busy=1 → pc unchanged. Register write during busy → committed.
- cpu_rst_n low in REQ → mem_wvalid=0 asynchronously, pc=RESET_PC. After release, no stale request is reissued.
